// File: rtl/bsg_chip_clk_monitor_counter.sv
// Counts rising edges of one selected asynchronous clock-monitor input over a programmable
// window of clk_i cycles and returns a saturating result through a valid/yumi handshake.
module bsg_chip_clk_monitor_counter #(
   parameter int unsigned els_p          = 8,
   parameter int unsigned lg_els_lp      = (els_p > 1) ? $clog2(els_p) : 1,
   parameter int unsigned window_width_p = 16,
   parameter int unsigned count_width_p  = 16,
   parameter int unsigned sync_stages_p  = 2
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [els_p-1:0]          mon_i,
   input  logic                      start_v_i,
   output logic                      start_ready_o,
   input  logic [lg_els_lp-1:0]      sel_i,
   input  logic [window_width_p-1:0] window_i,
   output logic                      v_o,
   output logic [count_width_p-1:0]  count_o,
   output logic                      overflow_o,
   output logic [lg_els_lp-1:0]      sel_o,
   input  logic                      yumi_i
);

   localparam int unsigned settle_width_lp = $clog2(sync_stages_p + 2);
   localparam int unsigned mux_width_lp    = 1 << lg_els_lp;
   localparam logic [settle_width_lp-1:0] settle_init_lp = settle_width_lp'(sync_stages_p + 1);
   localparam logic [settle_width_lp-1:0] settle_last_lp = settle_width_lp'(1);
   localparam logic [window_width_p-1:0]  win_zero_lp    = '0;
   localparam logic [window_width_p-1:0]  win_last_lp    = window_width_p'(1);

   typedef enum logic [1:0] {StIdle, StSettle, StCount, StDone} state_e;

   state_e                      r_state;
   logic                        r_ready;
   logic                        r_v;
   logic [lg_els_lp-1:0]        r_sel;
   logic [window_width_p-1:0]   r_win_cnt;
   logic [settle_width_lp-1:0]  r_settle;
   logic [count_width_p-1:0]    r_count;
   logic                        r_ovf;
   logic [sync_stages_p-1:0]    r_sync;
   logic                        r_prev;

   logic [mux_width_lp-1:0]     w_mon_pad;
   logic                        w_mon_sel;
   logic                        w_sync_last;
   logic                        w_rise;

   // Indices at or above els_p land on zero padding, so they read as a constant-low source.
   always_comb begin
      w_mon_pad              = '0;
      w_mon_pad[els_p-1:0]   = mon_i;
   end

   assign w_mon_sel   = w_mon_pad[r_sel];
   assign w_sync_last = r_sync[sync_stages_p-1];
   assign w_rise      = w_sync_last & ~r_prev;

   // Synchroniser and edge history run in every state so SETTLE can flush stale contents.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[sync_stages_p-2:0], w_mon_sel};
         r_prev <= w_sync_last;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state   <= StIdle;
         r_ready   <= 1'b1;
         r_v       <= 1'b0;
         r_sel     <= '0;
         r_win_cnt <= '0;
         r_settle  <= '0;
         r_count   <= '0;
         r_ovf     <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (start_v_i) begin
                  r_sel     <= sel_i;
                  r_win_cnt <= window_i;
                  r_count   <= '0;
                  r_ovf     <= 1'b0;
                  r_settle  <= settle_init_lp;
                  r_ready   <= 1'b0;
                  r_state   <= StSettle;
               end
            end
            StSettle: begin
               if (r_settle == settle_last_lp) begin
                  if (r_win_cnt != win_zero_lp) begin
                     r_state <= StCount;
                  end else begin
                     r_v     <= 1'b1;
                     r_state <= StDone;
                  end
               end else begin
                  r_settle <= r_settle - settle_last_lp;
               end
            end
            StCount: begin
               if (w_rise) begin
                  if (&r_count) begin
                     r_ovf <= 1'b1;
                  end else begin
                     r_count <= r_count + 1'b1;
                  end
               end
               if (r_win_cnt == win_last_lp) begin
                  r_v     <= 1'b1;
                  r_state <= StDone;
               end else begin
                  r_win_cnt <= r_win_cnt - win_last_lp;
               end
            end
            StDone: begin
               // Result registers are left intact; only the valid drops.
               if (yumi_i) begin
                  r_v     <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign start_ready_o = r_ready;
   assign v_o           = r_v;
   assign count_o       = r_count;
   assign overflow_o    = r_ovf;
   assign sel_o         = r_sel;

endmodule

// File: tb/tb_bsg_chip_clk_monitor_counter.sv
// Directed bench: expected results are queued on each start handshake and compared when v_o rises.
module tb_bsg_chip_clk_monitor_counter;

   localparam int unsigned S = 2;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start;
   logic        yumi;
   logic        which;
   logic [3:0]  sel;
   logic [15:0] win;
   logic [1:0]  mode [9];
   logic [8:0]  mon;
   logic [31:0] tb_cyc = '0;

   logic        a_ready, a_v, a_ovf;
   logic [15:0] a_count;
   logic [2:0]  a_sel;
   logic        b_ready, b_v, b_ovf;
   logic [3:0]  b_count;
   logic [3:0]  b_sel;

   logic        o_ready, o_v, o_ovf;
   logic [15:0] o_count;
   logic [3:0]  o_sel;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] count;
      logic        ovf;
      logic [3:0]  sel;
      int          lat;
   } exp_t;
   exp_t sb[$];

   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   // Mode per channel: 0 low, 1 high, 2 period-2 square wave, 3 period-4 square wave.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         mon[i] = (mode[i] == 2'd0) ? 1'b0 :
                  (mode[i] == 2'd1) ? 1'b1 :
                  (mode[i] == 2'd2) ? tb_cyc[0] : tb_cyc[1];
      end
   end

   bsg_chip_clk_monitor_counter #(
      .els_p(8), .window_width_p(16), .count_width_p(16), .sync_stages_p(S)
   ) dut_a (
      .clk_i(clk), .reset_i(reset), .mon_i(mon[7:0]),
      .start_v_i(start & ~which), .start_ready_o(a_ready),
      .sel_i(sel[2:0]), .window_i(win),
      .v_o(a_v), .count_o(a_count), .overflow_o(a_ovf), .sel_o(a_sel),
      .yumi_i(yumi & ~which)
   );

   bsg_chip_clk_monitor_counter #(
      .els_p(9), .window_width_p(16), .count_width_p(4), .sync_stages_p(S)
   ) dut_b (
      .clk_i(clk), .reset_i(reset), .mon_i(mon),
      .start_v_i(start & which), .start_ready_o(b_ready),
      .sel_i(sel), .window_i(win),
      .v_o(b_v), .count_o(b_count), .overflow_o(b_ovf), .sel_o(b_sel),
      .yumi_i(yumi & which)
   );

   always_comb begin
      o_ready = which ? b_ready : a_ready;
      o_v     = which ? b_v : a_v;
      o_ovf   = which ? b_ovf : a_ovf;
      o_count = which ? {12'd0, b_count} : a_count;
      o_sel   = which ? b_sel : {1'b0, a_sel};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      if (yumi === 1'b1) check("yumi_while_valid", {31'd0, o_v}, 32'd1);
   end

   function automatic int exp_cnt(input int edges, input int cw);
      return (edges > (1 << cw) - 1) ? (1 << cw) - 1 : edges;
   endfunction

   function automatic int exp_ovf(input int edges, input int cw);
      return (edges > (1 << cw) - 1) ? 1 : 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_req(input logic w, input logic [3:0] s, input logic [15:0] n,
                            input int c, input int o);
      exp_t e;
      which = w;
      sel   = s;
      win   = n;
      start = 1'b1;
      check("start_ready_o", {31'd0, o_ready}, 32'd1);
      e.count = c[15:0];
      e.ovf   = o[0];
      e.sel   = s;
      e.lat   = S + 2 + int'(n);
      sb.push_back(e);
      step();
      start = 1'b0;
   endtask

   task automatic wait_result(input bit do_yumi);
      exp_t e;
      int   lat;
      lat = 1;
      while (o_v !== 1'b1 && lat < 400) begin
         step();
         lat++;
      end
      e = sb.pop_front();
      check("v_o", {31'd0, o_v}, 32'd1);
      check("latency", lat, e.lat);
      check("count_o", {16'd0, o_count}, {16'd0, e.count});
      check("overflow_o", {31'd0, o_ovf}, {31'd0, e.ovf});
      check("sel_o", {28'd0, o_sel}, {28'd0, e.sel});
      if (do_yumi) begin
         yumi = 1'b1;
         step();
         yumi = 1'b0;
         check("v_o_after_yumi", {31'd0, o_v}, 32'd0);
         check("ready_after_yumi", {31'd0, o_ready}, 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      exp_t junk;
      reset = 1'b1; start = 1'b0; yumi = 1'b0; which = 1'b0; sel = '0; win = '0;
      for (int i = 0; i < 9; i++) mode[i] = 2'd0;
      repeat (3) step();
      reset = 1'b0;
      check("rst_ready", {31'd0, o_ready}, 32'd1);
      check("rst_v", {31'd0, o_v}, 32'd0);
      check("rst_count", {16'd0, o_count}, 32'd0);
      check("rst_ovf", {31'd0, o_ovf}, 32'd0);
      check("rst_sel", {28'd0, o_sel}, 32'd0);

      // Period-4 source, window 100.
      mode[3] = 2'd3;
      start_req(1'b0, 4'd3, 16'd100, exp_cnt(100 / 4, 16), exp_ovf(100 / 4, 16));
      wait_result(1'b1);

      // Constant-high source counts nothing.
      mode[0] = 2'd1;
      start_req(1'b0, 4'd0, 16'd50, 0, 0);
      wait_result(1'b1);

      // 4-bit counter saturates on a period-2 source.
      mode[1] = 2'd2;
      start_req(1'b1, 4'd1, 16'd64, exp_cnt(64 / 2, 4), exp_ovf(64 / 2, 4));
      wait_result(1'b1);

      // Out-of-range select reads as constant low even with every input toggling.
      for (int i = 0; i < 9; i++) mode[i] = 2'd2;
      start_req(1'b1, 4'd9, 16'd20, 0, 0);
      wait_result(1'b1);

      // Zero-length window.
      mode[3] = 2'd3;
      start_req(1'b0, 4'd3, 16'd0, 0, 0);
      wait_result(1'b1);

      // Back-pressure: result holds and a start pulse in DONE is ignored.
      start_req(1'b0, 4'd3, 16'd20, exp_cnt(20 / 4, 16), 0);
      wait_result(1'b0);
      for (int i = 0; i < 10; i++) begin
         check("bp_v", {31'd0, o_v}, 32'd1);
         check("bp_count", {16'd0, o_count}, 32'd5);
         check("bp_sel", {28'd0, o_sel}, 32'd3);
         check("bp_ready", {31'd0, o_ready}, 32'd0);
         if (i == 4) begin
            sel = 4'd6; win = 16'd1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
      yumi  = 1'b1;
      step();
      yumi  = 1'b0;
      check("bp_release_v", {31'd0, o_v}, 32'd0);
      check("bp_release_ready", {31'd0, o_ready}, 32'd1);
      repeat (3) step();
      check("bp_no_launch_v", {31'd0, o_v}, 32'd0);
      check("bp_no_launch_ready", {31'd0, o_ready}, 32'd1);
      check("bp_no_latch_sel", {28'd0, o_sel}, 32'd3);

      // Reset on COUNT cycle 40 discards the partial measurement.
      start_req(1'b0, 4'd3, 16'd100, 25, 0);
      repeat (S + 1 + 39) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      junk = sb.pop_back();
      check("mid_rst_v", {31'd0, o_v}, 32'd0);
      check("mid_rst_count", {16'd0, o_count}, 32'd0);
      check("mid_rst_ready", {31'd0, o_ready}, 32'd1);
      check("mid_rst_sel", {28'd0, o_sel}, 32'd0);
      step();
      start_req(1'b0, 4'd3, 16'd100, exp_cnt(100 / 4, 16), 0);
      wait_result(1'b1);
      check("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
